dfe_stage_capture: RTL and testbench

- Parametrised debug/observation successor to the DFE top-level output/status muxing.
- Selects one of NUM_SRC DFE stage outputs (fractional decimator, IIR 2.4 MHz, IIR 1 MHz, CIC, …) and streams it out registered.
- Arms a trigger and captures a burst of up to DEPTH valid samples into an on-chip buffer for register-side readback.
- Keeps per-stage sticky overflow/underflow flags with write-1-to-clear, replacing the instantaneous, unlatched status mux.

---
 rtl/dfe_capture_pkg.sv | 29 ++
 rtl/dfe_stage_capture_if.sv | 38 +++
 rtl/dfe_capture_ram.sv | 40 ++++
 rtl/dfe_stage_capture.sv | 211 +++++++++++++++++++++
 tb/tb_dfe_stage_capture.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dfe_capture_pkg.sv
// ---------------------------------------------------------------------------
// dfe_capture_pkg
// Shared types and constants for the DFE stage observation/capture block.
//   cap_state_t : capture FSM state (IDLE / ARMED / CAPTURE / DONE)
//   trig_mode_t : trigger mode selected by cfg_mode
//   ST_*        : raw 2-bit state encodings as seen on the 'state' output
// ---------------------------------------------------------------------------
package dfe_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARMED   = 2'b01,
    CAPTURE = 2'b10,
    DONE    = 2'b11
  } cap_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'b00,  // first valid sample
    TRIG_OVF = 2'b01,  // valid sample coincident with overflow pulse
    TRIG_UDF = 2'b10,  // valid sample coincident with underflow pulse
    TRIG_MAG = 2'b11   // |sample| >= threshold
  } trig_mode_t;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ARMED   = 2'b01;
  localparam logic [1:0] ST_CAPTURE = 2'b10;
  localparam logic [1:0] ST_DONE    = 2'b11;

endpackage

// File: rtl/dfe_stage_capture_if.sv
// ---------------------------------------------------------------------------
// dfe_stage_capture_if
// Bundles the per-stage source bus and the capture-buffer readback bus.
//   src_data  : NUM_SRC x DATA_WIDTH samples, index 0 is source 1
//   src_valid : per-stage sample valid
//   src_ovf   : per-stage overflow pulse
//   src_udf   : per-stage underflow pulse
//   rd_en     : buffer read strobe
//   rd_addr   : buffer read address
//   rd_data   : buffer read data, one cycle after rd_en
// Modports: master = DFE stages + register side, slave = capture block.
// ---------------------------------------------------------------------------
interface dfe_stage_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SRC    = 4,
  parameter int DEPTH      = 64
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ovf;
  logic [NUM_SRC-1:0]                 src_udf;
  logic                               rd_en;
  logic [AW-1:0]                      rd_addr;
  logic [DATA_WIDTH-1:0]              rd_data;

  modport master (
    output src_data, src_valid, src_ovf, src_udf, rd_en, rd_addr,
    input  rd_data
  );

  modport slave (
    input  src_data, src_valid, src_ovf, src_udf, rd_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/dfe_capture_ram.sv
// ---------------------------------------------------------------------------
// dfe_capture_ram
// Simple dual-port DEPTH x DATA_WIDTH capture buffer.
//   clk, rst : clock; rst clears only the read-data register
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr          : read port, registered output rd_data
// A read and a write to the same address in one cycle return the old word.
// rd_data holds its value while rd_en is low.
// ---------------------------------------------------------------------------
module dfe_capture_ram #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 64,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; stale contents
  // after reset are expected and harmless.
  // NOTE: non-blocking assignments make the read below see the pre-write
  // word on an address collision, which is the read-old behaviour we want.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dfe_stage_capture.sv
// ---------------------------------------------------------------------------
// dfe_stage_capture
// Debug/observation tap for the DFE chain.
//   clk, rst         : system clock, synchronous active-high reset
//   bus (slave)      : stage sources and capture-buffer readback
//   cfg_sel          : source select, 0 = none, 1..NUM_SRC
//   cfg_len          : capture length 1..DEPTH
//   cfg_mode         : trigger mode (see trig_mode_t)
//   cfg_thresh       : unsigned magnitude threshold for TRIG_MAG
//   arm, abort       : start / cancel capture pulses
//   flag_clr         : write-1-to-clear for sticky flags
//   mon_out/mon_valid: live selected source, registered
//   state, done      : FSM state, done = (state == DONE)
//   cap_count        : samples written in current/last capture
//   sticky_ovf/udf   : latched per-source overflow/underflow
// ---------------------------------------------------------------------------
module dfe_stage_capture
  import dfe_capture_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_SRC    = 4,
  parameter  int DEPTH      = 64,
  localparam int SEL_W      = $clog2(NUM_SRC + 1),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  dfe_stage_capture_if.slave    bus,
  input  logic [SEL_W-1:0]      cfg_sel,
  input  logic [AW:0]           cfg_len,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_thresh,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [NUM_SRC-1:0]    flag_clr,
  output logic [DATA_WIDTH-1:0] mon_out,
  output logic                  mon_valid,
  output logic [1:0]            state,
  output logic [AW:0]           cap_count,
  output logic                  done,
  output logic [NUM_SRC-1:0]    sticky_ovf,
  output logic [NUM_SRC-1:0]    sticky_udf
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_SRC);
  localparam logic [AW:0]      LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE     = (AW+1)'(1);

  cap_state_t            cur, nxt;
  logic [SEL_W-1:0]      lat_sel;
  logic [AW:0]           lat_len;
  trig_mode_t            lat_mode;
  logic [DATA_WIDTH-1:0] lat_thresh;

  logic [DATA_WIDTH-1:0] mon_d;
  logic                  mon_v;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_valid, cap_ovf, cap_udf;
  logic [DATA_WIDTH:0]   sx, mag;
  logic                  trig_hit, arm_ok, last_write;
  logic                  arm_take, wr_en;
  logic [AW-1:0]         wr_addr;

  // Live mux for the monitor path; out-of-range selects fall through to 0.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    mon_d = '0;
    mon_v = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cfg_sel == SEL_W'(i + 1)) begin
        mon_d = bus.src_data[i];
        mon_v = bus.src_valid[i];
      end
    end
  end

  // Mux for the source latched at arm time.
  always_comb begin
    cap_data  = '0;
    cap_valid = 1'b0;
    cap_ovf   = 1'b0;
    cap_udf   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (lat_sel == SEL_W'(i + 1)) begin
        cap_data  = bus.src_data[i];
        cap_valid = bus.src_valid[i];
        cap_ovf   = bus.src_ovf[i];
        cap_udf   = bus.src_udf[i];
      end
    end
  end

  // One extra bit so the most-negative sample yields 2^(DATA_WIDTH-1).
  assign sx  = {cap_data[DATA_WIDTH-1], cap_data};
  assign mag = sx[DATA_WIDTH] ? ('0 - sx) : sx;

  always_comb begin
    trig_hit = 1'b0;
    if (cap_valid) begin
      case (lat_mode)
        TRIG_IMM: trig_hit = 1'b1;
        TRIG_OVF: trig_hit = cap_ovf;
        TRIG_UDF: trig_hit = cap_udf;
        TRIG_MAG: trig_hit = (mag >= {1'b0, lat_thresh});
        default:  trig_hit = 1'b0;
      endcase
    end
  end

  assign arm_ok     = (cfg_sel != '0) && (cfg_sel <= SEL_MAX) &&
                      (cfg_len != '0) && (cfg_len <= LEN_MAX);
  assign last_write = ((cap_count + ONE) == lat_len);

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // FSM: next state. abort takes priority over arm, trigger and final write.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (arm && !abort && arm_ok) nxt = ARMED;
      end
      ARMED: begin
        if (abort)         nxt = IDLE;
        else if (trig_hit) nxt = (lat_len == ONE) ? DONE : CAPTURE;
      end
      CAPTURE: begin
        if (abort)                        nxt = IDLE;
        else if (cap_valid && last_write) nxt = DONE;
      end
      DONE: begin
        if (abort)               nxt = IDLE;
        else if (arm && arm_ok)  nxt = ARMED;
      end
      default: nxt = IDLE;
    endcase
  end

  // FSM: outputs and datapath strobes.
  always_comb begin
    arm_take = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = cap_count[AW-1:0];
    done     = 1'b0;
    case (cur)
      IDLE: arm_take = arm && !abort && arm_ok;
      ARMED: begin
        wr_en   = trig_hit && !abort;
        wr_addr = '0;
      end
      CAPTURE: wr_en = cap_valid && !abort;
      DONE: begin
        done     = 1'b1;
        arm_take = arm && !abort && arm_ok;
      end
      default: ;
    endcase
  end

  assign state = cur;

  // Configuration latch, capture counter, monitor register, sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sel    <= '0;
      lat_len    <= '0;
      lat_mode   <= TRIG_IMM;
      lat_thresh <= '0;
      cap_count  <= '0;
      mon_out    <= '0;
      mon_valid  <= 1'b0;
      sticky_ovf <= '0;
      sticky_udf <= '0;
    end else begin
      if (arm_take) begin
        lat_sel    <= cfg_sel;
        lat_len    <= cfg_len;
        lat_mode   <= trig_mode_t'(cfg_mode);
        lat_thresh <= cfg_thresh;
        cap_count  <= '0;
      end else if (wr_en) begin
        cap_count  <= (cur == ARMED) ? ONE : cap_count + ONE;
      end
      mon_out    <= mon_d;
      mon_valid  <= mon_v;
      // Set has priority over clear.
      sticky_ovf <= (sticky_ovf & ~flag_clr) | bus.src_ovf;
      sticky_udf <= (sticky_udf & ~flag_clr) | bus.src_udf;
    end
  end

  dfe_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (cap_data),
    .rd_en   (bus.rd_en),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_dfe_stage_capture.sv
// ---------------------------------------------------------------------------
// tb_dfe_stage_capture
// Directed bench for dfe_stage_capture. Expected monitor samples and read
// data are queued by the stimulus; monitors pop and compare when the DUT
// presents mon_valid or returns read data. Status outputs are checked
// directly at known points.
// ---------------------------------------------------------------------------
module tb_dfe_stage_capture;

  localparam int DW    = 16;
  localparam int NS    = 4;
  localparam int DEPTH = 64;
  localparam int SEL_W = 3;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dfe_stage_capture_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .DEPTH(DEPTH)) bus ();

  logic [SEL_W-1:0] cfg_sel;
  logic [AW:0]      cfg_len;
  logic [1:0]       cfg_mode;
  logic [DW-1:0]    cfg_thresh;
  logic             arm, abort;
  logic [NS-1:0]    flag_clr;
  logic [DW-1:0]    mon_out;
  logic             mon_valid;
  logic [1:0]       state;
  logic [AW:0]      cap_count;
  logic             done;
  logic [NS-1:0]    sticky_ovf, sticky_udf;

  dfe_stage_capture #(.DATA_WIDTH(DW), .NUM_SRC(NS), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_sel    (cfg_sel),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .arm        (arm),
    .abort      (abort),
    .flag_clr   (flag_clr),
    .mon_out    (mon_out),
    .mon_valid  (mon_valid),
    .state      (state),
    .cap_count  (cap_count),
    .done       (done),
    .sticky_ovf (sticky_ovf),
    .sticky_udf (sticky_udf)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] mon_q[$];
  logic [DW-1:0] rd_q[$];
  bit            mon_strict = 1'b0;
  logic          rd_en_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read-data valid marker: rd_en seen at a clock edge means data one edge later.
  always @(posedge clk) rd_en_d <= bus.rd_en;

  always @(negedge clk) begin
    if (mon_valid === 1'b1) begin
      if (mon_q.size() > 0)  check("mon_out", 32'(mon_out), 32'(mon_q.pop_front()));
      else if (mon_strict)   check("mon_unexpected_valid", 32'(mon_valid), 32'd0);
    end
    if (rd_en_d === 1'b1) begin
      if (rd_q.size() > 0) check("rd_data", 32'(bus.rd_data), 32'(rd_q.pop_front()));
      else                 check("rd_unexpected", 32'(rd_q.size()), 32'd1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of source 1 (index 0) stimulus.
  task automatic step(input logic [DW-1:0] d, input logic v, input logic ovf = 1'b0);
    bus.src_data[0]  = d;
    bus.src_valid[0] = v;
    bus.src_ovf[0]   = ovf;
    tick();
    bus.src_ovf[0]   = 1'b0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a[AW-1:0];
    rd_q.push_back(exp);
    tick();
    bus.rd_en   = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic chk_st(input string name, input logic [1:0] st, input int cnt);
    check({name, "_state"}, 32'(state), 32'(st));
    check({name, "_cap_count"}, 32'(cap_count), 32'(cnt));
  endtask

  initial begin
    rst         = 1'b1;
    cfg_sel     = '0;
    cfg_len     = '0;
    cfg_mode    = '0;
    cfg_thresh  = '0;
    arm         = 1'b0;
    abort       = 1'b0;
    flag_clr    = '0;
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.src_ovf   = '0;
    bus.src_udf   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;

    // Reset values.
    tick(2);
    chk_st("reset", 2'b00, 0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_mon_valid", 32'(mon_valid), 32'd0);
    check("reset_mon_out", 32'(mon_out), 32'd0);
    check("reset_sticky_ovf", 32'(sticky_ovf), 32'd0);
    check("reset_sticky_udf", 32'(sticky_udf), 32'd0);
    check("reset_rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b0;
    tick();

    // Monitor path: source 2 ramp, latency 1.
    cfg_sel    = 3'd2;
    mon_strict = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.src_data[1]  = 16'h0100 + 16'(k);
      bus.src_valid[1] = 1'b1;
      mon_q.push_back(16'h0100 + 16'(k));
      tick();
    end
    cfg_sel = 3'd0;
    tick();
    check("sel0_mon_valid", 32'(mon_valid), 32'd0);
    check("sel0_mon_out", 32'(mon_out), 32'd0);
    bus.src_valid[1] = 1'b0;
    tick();
    mon_strict = 1'b0;
    check("mon_q_drained", 32'(mon_q.size()), 32'd0);

    // Immediate trigger, len 8, valid every other cycle.
    cfg_sel  = 3'd1;
    cfg_len  = 7'd8;
    cfg_mode = 2'b00;
    do_arm();
    chk_st("imm_armed", 2'b01, 0);
    for (int v = 0; v <= 20; v++) begin
      step(16'(v), 1'b1);
      if (v == 3) chk_st("imm_mid", 2'b10, 4);
      step(16'hDEAD, 1'b0);
    end
    chk_st("imm_done", 2'b11, 8);
    check("imm_done_flag", 32'(done), 32'd1);
    for (int a = 0; a < 8; a++) rd(a, 16'(a));
    bus.rd_addr = 6'd5;
    tick(2);
    check("rd_hold", 32'(bus.rd_data), 32'd7);

    // Magnitude trigger at the threshold boundary (|0xC000| == 0x4000).
    cfg_mode   = 2'b11;
    cfg_thresh = 16'h4000;
    cfg_len    = 7'd2;
    do_arm();
    chk_st("mag_armed", 2'b01, 0);
    step(16'h1000, 1'b1);
    step(16'h3FFF, 1'b1);
    chk_st("mag_below", 2'b01, 0);
    step(16'hC000, 1'b1);
    chk_st("mag_trig", 2'b10, 1);
    step(16'h0005, 1'b1);
    chk_st("mag_done", 2'b11, 2);
    rd(0, 16'hC000);
    rd(1, 16'h0005);

    // Most-negative sample against thresh 0x7FFF, len 1 goes straight to DONE.
    cfg_thresh = 16'h7FFF;
    cfg_len    = 7'd1;
    do_arm();
    step(16'h7FFE, 1'b1);
    chk_st("mag_7ffe", 2'b01, 0);
    step(16'h8000, 1'b1);
    chk_st("mag_8000", 2'b11, 1);
    rd(0, 16'h8000);
    rd(1, 16'h0005);

    // Overflow trigger, full-depth capture, no wrap.
    cfg_mode = 2'b01;
    cfg_len  = 7'd64;
    do_arm();
    step(16'h0AAA, 1'b1);
    step(16'h0BBB, 1'b0, 1'b1);
    chk_st("ovf_novalid", 2'b01, 0);
    step(16'h0123, 1'b1, 1'b1);
    chk_st("ovf_trig", 2'b10, 1);
    for (int j = 1; j < 64; j++) step(16'h0200 + 16'(j), 1'b1);
    chk_st("ovf_full", 2'b11, 64);
    repeat (3) step(16'h7777, 1'b1);
    chk_st("ovf_hold", 2'b11, 64);
    rd(0, 16'h0123);
    for (int j = 1; j < 64; j++) rd(j, 16'h0200 + 16'(j));
    check("ovf_sticky0", 32'(sticky_ovf), 32'h1);

    // Abort handling.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_st("abort_done", 2'b00, 64);
    cfg_mode = 2'b00;
    cfg_len  = 7'd8;
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    chk_st("arm_abort", 2'b00, 64);
    do_arm();
    chk_st("rearm", 2'b01, 0);
    for (int j = 0; j < 5; j++) step(16'h0300 + 16'(j), 1'b1);
    chk_st("cap5", 2'b10, 5);
    abort = 1'b1;
    step(16'h5555, 1'b1);
    abort = 1'b0;
    chk_st("abort_cap", 2'b00, 5);
    for (int j = 0; j < 5; j++) rd(j, 16'h0300 + 16'(j));
    rd(5, 16'h0205);
    cfg_len = 7'd0;
    do_arm();
    chk_st("arm_len0", 2'b00, 5);
    cfg_len = 7'd65;
    do_arm();
    chk_st("arm_len65", 2'b00, 5);
    cfg_len = 7'd8;
    cfg_sel = 3'd5;
    do_arm();
    chk_st("arm_sel5", 2'b00, 5);
    cfg_sel = 3'd1;

    // Sticky flags.
    flag_clr = 4'hF;
    tick();
    flag_clr = 4'h0;
    check("sticky_clr_all", 32'(sticky_ovf), 32'h0);
    bus.src_ovf[3] = 1'b1;
    tick();
    bus.src_ovf[3] = 1'b0;
    check("sticky_set3", 32'(sticky_ovf), 32'h8);
    bus.src_ovf[3] = 1'b1;
    flag_clr       = 4'b1000;
    tick();
    bus.src_ovf[3] = 1'b0;
    flag_clr       = 4'h0;
    check("sticky_set_wins", 32'(sticky_ovf), 32'h8);
    flag_clr = 4'b1000;
    tick();
    flag_clr = 4'h0;
    check("sticky_clr3", 32'(sticky_ovf), 32'h0);
    bus.src_udf[1] = 1'b1;
    tick();
    bus.src_udf[1] = 1'b0;
    check("sticky_udf1", 32'(sticky_udf), 32'h2);
    check("sticky_ovf_indep", 32'(sticky_ovf), 32'h0);
    flag_clr = 4'b0001;
    tick();
    flag_clr = 4'h0;
    check("sticky_udf_other_clr", 32'(sticky_udf), 32'h2);

    // Reset mid-capture.
    do_arm();
    step(16'h0400, 1'b1);
    step(16'h0401, 1'b1);
    chk_st("pre_rst", 2'b10, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_st("mid_rst", 2'b00, 0);
    check("mid_rst_udf", 32'(sticky_udf), 32'h0);

    tick(2);
    check("mon_q_empty", 32'(mon_q.size()), 32'd0);
    check("rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
